// File: rtl/eth_stats_frame_monitor.sv
// eth_stats_frame_monitor
// Passive AXI-Stream tap producing one statistics event per completed frame:
// byte count (popcount of tkeep, 17-bit saturating) and good/bad status.
// Optional build macro: ETH_STATS_SIZE_CHECK_EN adds runt/giant size gating.
// Handshake: a beat is counted only when s_axis_tvalid & s_axis_tready are
// both high at a clk edge; this block never drives tready. The event outputs
// are a single-cycle valid pulse with no back-pressure.
module eth_stats_frame_monitor #(
    parameter int DATA_W        = 32,
    parameter int KEEP_W        = DATA_W / 8,
    parameter bit SYNC_ON_RESET = 1'b1
`ifdef ETH_STATS_SIZE_CHECK_EN
    ,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tready,
    output logic              valid,
    output logic [16:0]       frame_length,
    output logic              frame_good,
    output logic              overflow
`ifdef ETH_STATS_SIZE_CHECK_EN
    ,
    output logic              runt,
    output logic              giant
`endif
);

    localparam int          CNT_W   = $clog2(KEEP_W + 1);
    localparam logic [16:0] LEN_MAX = 17'h1FFFF;

    // SYNC: discarding a frame already in flight; IDLE: between frames;
    // ACTIVE: inside a frame. state_q is the observable state for checkers.
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic [CNT_W-1:0] beat_bytes;
    logic             emit;
    logic             load;

    logic [16:0] len_q;
    logic        err_q;
    logic        sat_q;

    logic [16:0] base_len;
    logic        base_err;
    logic        base_sat;
    logic [17:0] sum_wide;
    logic [16:0] cur_len;
    logic        cur_err;
    logic        cur_sat;

    assign accept = s_axis_tvalid & s_axis_tready;

    // Popcount of tkeep; holes in tkeep are legal and simply not counted.
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            beat_bytes = beat_bytes + CNT_W'(s_axis_tkeep[i]);
        end
    end

    // Running totals including the current beat; a frame starting in IDLE
    // begins from zero so back-to-back frames need no clearing cycle.
    always_comb begin
        base_len = (state_q == ST_ACTIVE) ? len_q : 17'd0;
        base_err = (state_q == ST_ACTIVE) ? err_q : 1'b0;
        base_sat = (state_q == ST_ACTIVE) ? sat_q : 1'b0;
        sum_wide = {1'b0, base_len} + 18'(beat_bytes);
        cur_sat  = base_sat | sum_wide[17];
        cur_len  = sum_wide[17] ? LEN_MAX : sum_wide[16:0];
        cur_err  = base_err | s_axis_tuser;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SYNC_ON_RESET ? ST_SYNC : ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the emit/load strobes for the datapath.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (accept && s_axis_tlast) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        emit = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame accumulators; only meaningful while ACTIVE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q <= '0;
            err_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (load) begin
            len_q <= cur_len;
            err_q <= cur_err;
            sat_q <= cur_sat;
        end
    end

`ifdef ETH_STATS_SIZE_CHECK_EN
    localparam logic [16:0] MIN_L = 17'(MIN_FRAME_LEN);
    localparam logic [16:0] MAX_L = 17'(MAX_FRAME_LEN);

    logic cur_runt;
    logic cur_giant;

    assign cur_runt  = cur_len < MIN_L;
    assign cur_giant = (cur_len > MAX_L) | cur_sat;

    // Registered event outputs; payload holds until the next event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            frame_length <= '0;
            frame_good   <= 1'b0;
            overflow     <= 1'b0;
            runt         <= 1'b0;
            giant        <= 1'b0;
        end else begin
            valid <= emit;
            if (emit) begin
                frame_length <= cur_len;
                frame_good   <= ~cur_err & ~cur_sat & ~cur_runt & ~cur_giant;
                overflow     <= cur_sat;
                runt         <= cur_runt;
                giant        <= cur_giant;
            end
        end
    end
`else
    // Registered event outputs; payload holds until the next event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            frame_length <= '0;
            frame_good   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            valid <= emit;
            if (emit) begin
                frame_length <= cur_len;
                frame_good   <= ~cur_err & ~cur_sat;
                overflow     <= cur_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_stats_frame_monitor.sv
// Testbench for eth_stats_frame_monitor: two instances share one stimulus
// stream (SYNC_ON_RESET=0 and =1); a frame-level reference model pushes the
// expected event per instance, a negedge monitor pops and compares.
module tb_eth_stats_frame_monitor;

  localparam int KEEP_W = 4;
  localparam int LEN_CAP = 131071;
`ifdef ETH_STATS_SIZE_CHECK_EN
  localparam int EXP_W = 21;
`else
  localparam int EXP_W = 19;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [KEEP_W-1:0] tkeep = '0;
  logic tuser = 1'b0, tlast = 1'b0, tvalid = 1'b0, tready = 1'b0;

  logic v0, good0, ovf0, v1, good1, ovf1;
  logic [16:0] len0, len1;
`ifdef ETH_STATS_SIZE_CHECK_EN
  logic runt0, giant0, runt1, giant1;
`endif

  eth_stats_frame_monitor #(.DATA_W(32), .SYNC_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .valid(v0), .frame_length(len0), .frame_good(good0), .overflow(ovf0)
`ifdef ETH_STATS_SIZE_CHECK_EN
    , .runt(runt0), .giant(giant0)
`endif
  );

  eth_stats_frame_monitor #(.DATA_W(32), .SYNC_ON_RESET(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .valid(v1), .frame_length(len1), .frame_good(good1), .overflow(ovf1)
`ifdef ETH_STATS_SIZE_CHECK_EN
    , .runt(runt1), .giant(giant1)
`endif
  );

  // scoreboard state
  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int total_cnt = 0;
  int bad_cnt = 0;

  // reference model: per-instance frame totals and discard flag
  int m_tot[2];
  bit m_err[2];
  bit m_sync[2];
  bit sync_cfg[2] = '{1'b0, 1'b1};

  function automatic int pop_keep(input logic [KEEP_W-1:0] k);
    int n = 0;
    for (int i = 0; i < KEEP_W; i++) if (k[i]) n++;
    return n;
  endfunction

  function automatic logic [EXP_W-1:0] make_exp(input int tot, input bit err);
    logic [16:0] len;
    bit ovf, good;
    ovf = tot > LEN_CAP;
    len = ovf ? 17'(LEN_CAP) : 17'(tot);
    good = !err && !ovf;
`ifdef ETH_STATS_SIZE_CHECK_EN
    begin
      bit runt, giant;
      runt = tot < 64;
      giant = tot > 1518;
      good = good && !runt && !giant;
      return {len, good, ovf, runt, giant};
    end
`else
    return {len, good, ovf};
`endif
  endfunction

  task automatic model_accept(input logic [KEEP_W-1:0] k, input bit user, input bit last);
    for (int i = 0; i < 2; i++) begin
      if (m_sync[i]) begin
        if (last) m_sync[i] = 1'b0;
      end else begin
        m_tot[i] += pop_keep(k);
        m_err[i] = m_err[i] | user;
        if (last) begin
          if (i == 0) exp_q0.push_back(make_exp(m_tot[i], m_err[i]));
          else exp_q1.push_back(make_exp(m_tot[i], m_err[i]));
          m_tot[i] = 0;
          m_err[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_tot[i] = 0;
      m_err[i] = 1'b0;
      m_sync[i] = sync_cfg[i];
    end
  endtask

  // driver tasks
  task automatic drive(input logic [KEEP_W-1:0] k, input bit user, input bit last,
                       input bit vld, input bit rdy);
    @(posedge clk);
    #1;
    tkeep = k; tuser = user; tlast = last; tvalid = vld; tready = rdy;
    if (vld && rdy) model_accept(k, user, last);
  endtask

  task automatic beat(input logic [KEEP_W-1:0] k, input bit user, input bit last);
    drive(k, user, last, 1'b1, 1'b1);
  endtask

  task automatic idle_cycle();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int nbytes, input bit user);
    int rem = nbytes;
    logic [KEEP_W-1:0] k;
    while (rem > KEEP_W) begin
      beat('1, 1'b0, 1'b0);
      rem -= KEEP_W;
    end
    k = KEEP_W'((1 << rem) - 1);
    beat(k, user, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pop and compare whenever an instance presents an event
  task automatic mon_check(input int idx, input logic [EXP_W-1:0] act);
    logic [EXP_W-1:0] exp;
    total_cnt++;
    if ((idx == 0 && exp_q0.size() == 0) || (idx == 1 && exp_q1.size() == 0)) begin
      bad_cnt++;
      $display("FAIL event_dut%0d: unexpected event got %h expected none at %0t", idx, act, $time);
    end else begin
      exp = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (act !== exp) begin
        bad_cnt++;
        $display("FAIL event_dut%0d: got len=%0d good/ovf..=%b expected len=%0d good/ovf..=%b at %0t",
                 idx, act[EXP_W-1 -: 17], act[EXP_W-18:0], exp[EXP_W-1 -: 17], exp[EXP_W-18:0], $time);
      end
    end
  endtask

  always @(negedge clk) begin
`ifdef ETH_STATS_SIZE_CHECK_EN
    if (v0 === 1'b1) mon_check(0, {len0, good0, ovf0, runt0, giant0});
    if (v1 === 1'b1) mon_check(1, {len1, good1, ovf1, runt1, giant1});
`else
    if (v0 === 1'b1) mon_check(0, {len0, good0, ovf0});
    if (v1 === 1'b1) mon_check(1, {len1, good1, ovf1});
`endif
  end

  // watchdog
  initial begin
    #5_000_000;
    bad_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // main stimulus
  initial begin
    int nb, wait_cyc;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid0", v0, 0);
    chk("reset_len0", len0, 0);
    chk("reset_good0", good0, 0);
    chk("reset_ovf0", ovf0, 0);
    chk("reset_valid1", v1, 0);
    chk("reset_len1", len1, 0);

    // 64-byte frame; dut1 is still discarding after reset
    send_frame(64, 1'b0);
    idle_cycle();
    @(negedge clk);
    chk("latency_valid0", v0, 1);
    chk("sync_drop_valid1", v1, 0);
    @(negedge clk);
    chk("pulse_width_valid0", v0, 0);

    // stalled frame: tvalid without tready must not count
    beat(4'hF, 1'b0, 1'b0);
    drive(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(4'hF, 1'b1, 1'b0);
    drive(4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
    beat(4'h1, 1'b0, 1'b1);

    // back-to-back single-beat frames
    beat(4'h3, 1'b0, 1'b1);
    beat(4'h7, 1'b0, 1'b1);
    idle_cycle();
    @(negedge clk);
    chk("b2b_second_valid0", v0, 1);
    chk("b2b_second_len0", len0, 3);

    // zero-length frames, good and bad
    beat(4'h0, 1'b0, 1'b1);
    beat(4'h0, 1'b1, 1'b1);
    // sparse tkeep
    beat(4'h5, 1'b0, 1'b0);
    beat(4'hA, 1'b0, 1'b0);
    beat(4'h0, 1'b0, 1'b0);
    beat(4'h9, 1'b1, 1'b1);

    // saturation, then a normal frame afterwards
    for (int i = 0; i < 33000; i++) beat(4'hF, 1'b0, (i == 32999));
    beat(4'hF, 1'b0, 1'b1);

    // size boundary frames
    send_frame(60, 1'b0);
    send_frame(1518, 1'b0);
    send_frame(1519, 1'b0);
    send_frame(63, 1'b0);

    // randomized frames with stalls and gaps
    for (int f = 0; f < 60; f++) begin
      nb = $urandom_range(1, 12);
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          drive(KEEP_W'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 1)), 1'b0);
        end
        beat(KEEP_W'($urandom), ($urandom_range(0, 15) == 0), (b == nb - 1));
      end
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // reset mid-frame
    beat(4'hF, 1'b0, 1'b0);
    beat(4'hF, 1'b0, 1'b0);
    beat(4'hF, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) beat(4'hF, 1'b0, (i == 4));
    beat(4'hF, 1'b0, 1'b0);
    beat(4'hF, 1'b0, 1'b1);
    idle_cycle();

    // drain, bounded
    wait_cyc = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    chk("drain_q0_empty", exp_q0.size(), 0);
    chk("drain_q1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
